// File: rtl/axi_apb_pkg.sv
// Shared types and helpers for the AXI-to-APB bridge.
package axi_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } wr_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned clog2_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_chan_hold_reg.sv
// Single-entry valid/ready holding register for one AXI channel payload.
module axi_chan_hold_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  output logic             ready_c,
  input  logic [WIDTH-1:0] data,
  input  logic             clear,
  output logic             full,
  output logic [WIDTH-1:0] q
);

  assign ready_c = !full && rst_n;

  // A handshake can only occur while empty, so it never collides with clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      q    <= '0;
    end else if (valid && ready_c) begin
      full <= 1'b1;
      q    <= data;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_apb_wr_ctrl.sv
// AXI single-beat write path: pairs AW/W, runs one APB write per pair, returns B.
module axi_apb_wr_ctrl
  import axi_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned W_WIDTH    = DATA_WIDTH + STRB_WIDTH + 1;
  localparam int unsigned CNT_WIDTH  = clog2_w(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  wr_state_e               state;
  wr_state_e               next_state;
  logic                    aw_full;
  logic                    w_full;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [W_WIDTH-1:0]      w_q;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [STRB_WIDTH-1:0]   w_strb;
  logic                    w_last_err;
  logic                    pair_take_c;
  logic                    timeout_c;
  logic [CNT_WIDTH-1:0]    wait_cnt;

  logic                    psel_d;
  logic                    penable_d;
  logic                    pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_d;
  logic                    bvalid_d;
  logic [1:0]              bresp_d;

  assign {w_last_err, w_strb, w_data} = w_q;
  assign pair_take_c = (state == IDLE) && aw_full && w_full;
  assign timeout_c   = (TIMEOUT_CYCLES != 0) && (state == ACCESS) && !pready &&
                       (wait_cnt == CNT_LAST);

  axi_chan_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (awvalid),
    .ready_c (awready),
    .data    (awaddr),
    .clear   (pair_take_c),
    .full    (aw_full),
    .q       (aw_addr)
  );

  axi_chan_hold_reg #(.WIDTH(W_WIDTH)) u_w_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (wvalid),
    .ready_c (wready),
    .data    ({!wlast, wstrb, wdata}),
    .clear   (pair_take_c),
    .full    (w_full),
    .q       (w_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pair_take_c) next_state = w_last_err ? RESP : SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (pready || timeout_c) next_state = RESP;
      RESP:    if (bready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    psel_d    = (next_state == SETUP) || (next_state == ACCESS);
    penable_d = (next_state == ACCESS);
    pwrite_d  = psel_d;
    bvalid_d  = (next_state == RESP);
    paddr_d   = paddr;
    pwdata_d  = pwdata;
    pstrb_d   = pstrb;
    bresp_d   = bresp;
    if (pair_take_c) begin
      if (w_last_err) begin
        bresp_d = RESP_SLVERR;
      end else begin
        paddr_d  = aw_addr;
        pwdata_d = w_data;
        pstrb_d  = w_strb;
      end
    end
    if ((state == ACCESS) && (pready || timeout_c)) begin
      bresp_d = (pready && !pslverr) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      psel    <= psel_d;
      penable <= penable_d;
      pwrite  <= pwrite_d;
      paddr   <= paddr_d;
      pwdata  <= pwdata_d;
      pstrb   <= pstrb_d;
      bvalid  <= bvalid_d;
      bresp   <= bresp_d;
    end
  end

  // ACCESS wait counter, saturating so a disabled timeout never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !pready && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axi_apb_wr_ctrl.sv
// Scoreboard bench for axi_apb_wr_ctrl with an APB slave model and random traffic.
module tb_axi_apb_wr_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  axi_apb_wr_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          len;
  } apb_exp_t;

  typedef struct {
    int wt;
    bit err;
  } plan_t;

  apb_exp_t   apb_q[$];
  logic [1:0] b_q[$];
  plan_t      plan_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int bready_mode = 1;  // 0 random, 1 always high, 2 always low

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Reference model: one APB transfer per good beat, ACCESS length capped by timeout.
  function automatic void push_exp(input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] s, input bit last,
                                   input int wt, input bit err);
    if (last) begin
      apb_q.push_back('{a, d, s, (wt + 1 < TO) ? wt + 1 : TO});
      plan_q.push_back('{wt, err});
    end
    b_q.push_back((!last || wt >= TO || err) ? 2'b10 : 2'b00);
  endfunction

  task automatic send_aw(input logic [31:0] a, input int dly);
    bit rdy;
    int n;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = a;
    awvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); rdy = awready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 300);
    awvalid = 1'b0;
    if (!rdy) fail_now("aw_handshake", "awready stayed 0, expected 1");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input bit last, input int dly);
    bit rdy;
    int n;
    repeat (dly) begin @(posedge clk); #1; end
    wdata = d;
    wstrb = s;
    wlast = last;
    wvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); rdy = wready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 300);
    wvalid = 1'b0;
    if (!rdy) fail_now("w_handshake", "wready stayed 0, expected 1");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit last, input int wt, input bit err,
                          input int daw, input int dw);
    push_exp(a, d, s, last, wt, err);
    fork
      send_aw(a, daw);
      send_w(d, s, last, dw);
    join
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((b_q.size() != 0 || apb_q.size() != 0) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (b_q.size() != 0 || apb_q.size() != 0)
      fail_now("drain", $sformatf("%0d B / %0d APB responses outstanding, expected 0",
                                  b_q.size(), apb_q.size()));
    repeat (2) begin @(posedge clk); #1; end
  endtask

  always @(posedge clk) begin
    #1;
    case (bready_mode)
      0:       bready = ($urandom_range(0, 3) != 0);
      1:       bready = 1'b1;
      default: bready = 1'b0;
    endcase
  end

  // APB slave model: pready after the planned number of wait cycles.
  plan_t pl;
  int    s_wt = 0;
  int    s_acc = 0;
  bit    s_err = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pready = 1'b0; pslverr = 1'b0; s_acc = 0;
    end else if (psel && !penable) begin
      if (plan_q.size() != 0) begin
        pl = plan_q.pop_front(); s_wt = pl.wt; s_err = pl.err;
      end else begin
        s_wt = 0; s_err = 1'b0;
      end
      s_acc = 0; pready = 1'b0; pslverr = 1'b0;
    end else if (psel && penable) begin
      pready  = (s_acc == s_wt);
      pslverr = (s_acc == s_wt) && s_err;
      s_acc++;
    end else begin
      pready = 1'b0; pslverr = 1'b0;
    end
  end

  apb_exp_t cur;
  bit       have = 0;
  bit       in_xfer = 0;
  bit       unstable = 0;
  int       acc_len = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_xfer = 0;
    end else if (psel && !penable) begin
      if (apb_q.size() == 0) begin
        have = 0;
        fail_now("apb_unexpected", $sformatf("psel=1 paddr=%h, expected no transfer", paddr));
      end else begin
        cur = apb_q.pop_front();
        have = 1;
        check("paddr", 64'(paddr), 64'(cur.addr));
        check("pwdata", 64'(pwdata), 64'(cur.data));
        check("pstrb", 64'(pstrb), 64'(cur.strb));
        check("pwrite", 64'(pwrite), 64'd1);
      end
      in_xfer = 1; acc_len = 0; unstable = 0;
    end else if (psel && penable) begin
      acc_len++;
      if (have && (paddr !== cur.addr || pwdata !== cur.data || pstrb !== cur.strb)) unstable = 1;
    end else if (in_xfer) begin
      in_xfer = 0;
      if (have) begin
        check("access_len", 64'(acc_len), 64'(cur.len));
        check("apb_stable", 64'(unstable), 64'd0);
      end
    end
  end

  bit         hold_chk = 0;
  logic [1:0] hold_resp = 2'b00;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_chk = 0;
    end else begin
      if (hold_chk) begin
        check("bvalid_hold", 64'(bvalid), 64'd1);
        check("bresp_hold", 64'(bresp), 64'(hold_resp));
      end
      if (bvalid && bready) begin
        if (b_q.size() == 0) fail_now("b_unexpected", $sformatf("bvalid=1 bresp=%b, expected none", bresp));
        else check("bresp", 64'(bresp), 64'(b_q.pop_front()));
      end
      hold_chk = bvalid && !bready;
      hold_resp = bresp;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_pwrite", 64'(pwrite), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_pstrb", 64'(pstrb), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_bresp", 64'(bresp), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_awready", 64'(awready), 64'd1);
    check("post_rst_wready", 64'(wready), 64'd1);
    @(posedge clk); #1;

    // Minimum latency with AW and W in the same cycle.
    push_exp(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 1'b1, 0, 1'b0);
    awaddr = 32'h0000_1000; awvalid = 1'b1;
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk); check("lat_e0_psel", 64'(psel), 64'd0);
    @(negedge clk); check("lat_e1_psel", 64'(psel), 64'd1);
    check("lat_e1_penable", 64'(penable), 64'd0);
    @(negedge clk); check("lat_e2_penable", 64'(penable), 64'd1);
    check("lat_e2_bvalid", 64'(bvalid), 64'd0);
    @(negedge clk); check("lat_e3_bvalid", 64'(bvalid), 64'd1);
    check("lat_e3_psel", 64'(psel), 64'd0);
    @(posedge clk); #1;
    wait_idle(100);

    // W first, AW five cycles later.
    push_exp(32'h2000_0040, 32'h1234_5678, 4'h3, 1'b1, 0, 1'b0);
    send_w(32'h1234_5678, 4'h3, 1'b1, 0);
    repeat (5) begin
      @(negedge clk);
      check("order_wready", 64'(wready), 64'd0);
      check("order_psel", 64'(psel), 64'd0);
      @(posedge clk); #1;
    end
    awaddr = 32'h2000_0040; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk); check("order_psel_idle", 64'(psel), 64'd0);
    @(negedge clk); check("order_psel_setup", 64'(psel), 64'd1);
    wait_idle(100);

    // Wait states, slave error, timeout boundaries and a bad wlast beat.
    do_write(32'h0000_3000, 32'hCAFE_0001, 4'h1, 1'b1, 3, 1'b1, 0, 0);
    wait_idle(100);
    do_write(32'h0000_3004, 32'hCAFE_0002, 4'hF, 1'b1, 15, 1'b0, 0, 0);
    wait_idle(100);
    do_write(32'h0000_3008, 32'hCAFE_0003, 4'hF, 1'b1, 16, 1'b0, 0, 0);
    wait_idle(100);
    do_write(32'h0000_300C, 32'hCAFE_0004, 4'hC, 1'b1, 1000, 1'b0, 1, 0);
    wait_idle(100);
    do_write(32'h0000_4000, 32'hBAD0_BAD0, 4'hF, 1'b0, 0, 1'b0, 0, 2);
    wait_idle(100);
    do_write(32'h0000_4004, 32'h600D_600D, 4'hF, 1'b1, 0, 1'b0, 2, 0);
    wait_idle(100);

    // Response backpressure with a second pair queued behind it.
    bready_mode = 2;
    @(posedge clk); #1;
    do_write(32'h0000_5000, 32'h0000_5555, 4'hF, 1'b1, 0, 1'b0, 0, 0);
    do_write(32'h0000_5004, 32'h0000_6666, 4'hF, 1'b1, 1, 1'b0, 0, 0);
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    repeat (10) begin
      @(negedge clk);
      check("bp_bvalid", 64'(bvalid), 64'd1);
      check("bp_awready", 64'(awready), 64'd0);
      check("bp_wready", 64'(wready), 64'd0);
      check("bp_psel", 64'(psel), 64'd0);
      @(posedge clk); #1;
    end
    bready_mode = 1;
    wait_idle(100);

    // Randomised traffic.
    bready_mode = 0;
    for (int i = 0; i < 40; i++) begin
      int r;
      int wt;
      r = int'($urandom_range(0, 9));
      if (r == 0)      wt = TO + int'($urandom_range(0, 20));
      else if (r == 1) wt = TO - 1;
      else             wt = int'($urandom_range(0, 3));
      do_write($urandom, $urandom, 4'($urandom_range(0, 15)),
               ($urandom_range(0, 7) != 0), wt, ($urandom_range(0, 3) == 0),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    bready_mode = 1;
    wait_idle(2000);

    // Asynchronous reset in the middle of ACCESS.
    do_write(32'h0000_7000, 32'h7777_7777, 4'hF, 1'b1, 1000, 1'b0, 0, 0);
    n = 0;
    while (!(psel && penable) && n < 50) begin @(negedge clk); n++; end
    if (!(psel && penable)) fail_now("reset_access", "ACCESS phase never reached, expected penable=1");
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_psel", 64'(psel), 64'd0);
    check("mid_rst_penable", 64'(penable), 64'd0);
    check("mid_rst_bvalid", 64'(bvalid), 64'd0);
    check("mid_rst_awready", 64'(awready), 64'd0);
    check("mid_rst_paddr", 64'(paddr), 64'd0);
    apb_q.delete(); b_q.delete(); plan_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_write(32'h0000_8000, 32'h8888_8888, 4'h5, 1'b1, 1, 1'b0, 0, 0);
    wait_idle(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
